dequantize_block: RTL

DEQUANTIZE_BLOCK -- requirements
Module: dequantize_block

---
 rtl/dequantize_block.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dequantize_block.sv
// Dequantizer for 4x4 blocks: scales 16 zigzag-ordered levels by the DC/AC step,
// saturates to 16 bits, stores them in raster order and drains them with a handshake.
module dequantize_block (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] q_dc,
   input  logic signed [15:0] q_ac,
   input  logic               in_valid,
   input  logic signed [15:0] in_level,
   output logic               in_ready,
   output logic               out_valid,
   output logic signed [15:0] out_coeff,
   output logic               out_last,
   output logic               out_nz,
   input  logic               out_ready
);

   typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

   state_e             state_q, state_d;
   logic [3:0]         k_q, k_d;
   logic [3:0]         rd_q, rd_d;
   logic               nz_q, nz_d;
   logic signed [15:0] qac_q, qac_d;
   logic signed [15:0] mem_q [16];

   logic               in_fire;
   logic               out_fire;
   logic signed [15:0] q_sel;
   logic signed [31:0] prod;
   logic signed [15:0] prod_sat;
   logic [3:0]         waddr;

   // Scan index to raster address.
   function automatic logic [3:0] zigzag(input logic [3:0] k);
      logic [3:0] a;
      case (k)
         4'd0:    a = 4'd0;
         4'd1:    a = 4'd1;
         4'd2:    a = 4'd4;
         4'd3:    a = 4'd8;
         4'd4:    a = 4'd5;
         4'd5:    a = 4'd2;
         4'd6:    a = 4'd3;
         4'd7:    a = 4'd6;
         4'd8:    a = 4'd9;
         4'd9:    a = 4'd12;
         4'd10:   a = 4'd13;
         4'd11:   a = 4'd10;
         4'd12:   a = 4'd7;
         4'd13:   a = 4'd11;
         4'd14:   a = 4'd14;
         default: a = 4'd15;
      endcase
      return a;
   endfunction

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // The k=0 level uses the live q_dc, which is the value present at that transfer.
   always_comb begin
      q_sel = (state_q == StIdle) ? q_dc : qac_q;
      prod  = in_level * q_sel;
      if (prod > 32'sd32767) begin
         prod_sat = 16'sh7fff;
      end else if (prod < -32'sd32768) begin
         prod_sat = 16'sh8000;
      end else begin
         prod_sat = prod[15:0];
      end
      waddr = zigzag(k_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= 4'd0;
         rd_q    <= 4'd0;
         nz_q    <= 1'b0;
         qac_q   <= 16'sd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         rd_q    <= rd_d;
         nz_q    <= nz_d;
         qac_q   <= qac_d;
      end
   end

   // in_fire is already suppressed during reset, so the buffer needs no reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem_q[waddr] <= prod_sat;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_fire) state_d = StLoad;
         StLoad:  if (in_fire && k_q == 4'd15) state_d = StDrain;
         StDrain: if (out_fire && rd_q == 4'd15) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      k_d   = k_q;
      rd_d  = rd_q;
      nz_d  = nz_q;
      qac_d = qac_q;
      if (in_fire) begin
         k_d = k_q + 4'd1;
         if (state_q == StIdle) begin
            nz_d  = (prod_sat != 16'sd0);
            qac_d = q_ac;
         end else begin
            nz_d = nz_q | (prod_sat != 16'sd0);
         end
      end
      if (out_fire) begin
         rd_d = rd_q + 4'd1;
      end
   end

   always_comb begin
      in_ready  = !rst && (state_q != StDrain);
      out_valid = !rst && (state_q == StDrain);
      out_coeff = out_valid ? mem_q[rd_q] : 16'sd0;
      out_last  = out_valid && (rd_q == 4'd15);
      out_nz    = out_valid && nz_q;
   end

endmodule
